aes_inv_key_schedule: RTL
=========================

// Module: aes_inv_key_schedule
// PURPOSE
//  Decrypt-side AES-128 round-key source: walks the key expansion backwards, presenting round keys Nr..0 one at a time.
//  Replaces the 176-byte forward table with one 128-bit working register and 4 S-box lookups per step.
//  Sits beside the forward key schedule and feeds the inverse-cipher round engine via a Valid/Next handshake.
// PARAMETERS
//  NR      10   number of rounds; only 10 (AES-128) is supported, other values are a synthesis error
// PORTS
//  Clk     in   1    clock, rising edge
//  Rst     in   1    reset, asynchronous, active-high
//  Load    in   1    1-cycle pulse: capture KeyIn and start a new sequence
//  KeyIn   in   128  round-Nr key (cipher key with AES_FWD_PRELOAD_EN); byte 0 in [127:120]
//  Next    in   1    consumer has used Key; advance to previous round
//  Key     out  128  current round key, same byte order as KeyIn
//  Round   out  4    round index of Key (10..0)
//  Valid   out  1    Key/Round valid
//  Ry      out  1    Valid & (Round==0): last key presented
//  Busy    out  1    step or preload in progress
// BEHAVIOUR
//  Reset: Key=0, Round=0, Valid=0, Ry=0, Busy=0, state IDLE, byte counter=0.
//  States: IDLE -> HOLD -> SUB -> HOLD ... -> IDLE.
//   IDLE: Load -> Key<=KeyIn, Round<=NR, Valid=1 from the next edge, go to HOLD.
//   HOLD: Valid=1. Next & Round!=0 -> Valid=0, Busy=1, go to SUB, cnt=0.
//         Next & Round==0 -> Valid=0, Ry=0, go to IDLE.
//   SUB:  one S-box lookup per cycle on RotWord(p3), where p3=w3^w2; cnt 0..3 indexes the bytes.
//         On the 4th edge, combine: p3=w3^w2, p2=w2^w1, p1=w1^w0,
//         p0=w0^SubWord(RotWord(p3))^{Rcon[Round-1],00,00,00}.
//         Key<={p0,p1,p2,p3}, Round<=Round-1, Valid=1, Busy=0, go to HOLD.
//  Latency: Valid is low exactly 4 cycles between an accepted Next and the next key. Full 10-step walk is 11 keys, 5 cycles apart with Next held high.
//  Next while Valid=0 is ignored. Load is ignored while Rst is high.
//  Load has priority in every state, including mid-SUB: the step is aborted and the sequence restarts at Round=NR. Load & Next in the same cycle: Load wins.
//  Rst mid-operation: all outputs clear immediately (asynchronous); the partial step is discarded.
//  Rcon: 01,02,04,08,10,20,40,80,1B,36, indexed 0..9. Word wN occupies Key[127-32N -: 32].
// CONFIGURATION
//  AES_FWD_PRELOAD_EN defined:
//   - KeyIn is the cipher key (round 0).
//   - After Load, the block runs NR forward steps on the same S-box and counter: n0=w0^Sub(Rot(w3))^Rcon[r], n1=w1^n0, n2=w2^n1, n3=w3^n2.
//   - Each step takes 4 cycles, 40 in total. Busy=1 and Valid=0 throughout; Round counts 0..10.
//   - At the end the round-10 key is presented with Valid=1 and the block enters HOLD.
//   - Load during preload restarts it.
//  AES_FWD_PRELOAD_EN undefined: KeyIn is the round-10 key; Valid one cycle after Load; the forward-step logic is absent.
// STRUCTURE
//  Package aes_pkg holds:
//   - SBOX[0:255] and RCON[0:9] constant tables (shared with the forward key schedule);
//   - state encoding (IDLE/HOLD/SUB/PRE);
//   - byte_t and word_t typedefs.
//  Sub-module aes_sbox: combinational 8-bit lookup, one instance, time-multiplexed by cnt.
// TESTING
//  1 Reset asserted -> Key=0, Round=0, Valid=0, Ry=0, Busy=0, without waiting for a clock edge.
//  2 Load KeyIn=d014f9a8c9ee2589e13f0cc8b6630ca6 -> next cycle Valid=1, Round=10.
//    Then Next -> 4 cycles with Valid=0, then Key=ac7766f319fadc2128d12941575c006e, Round=9.
//  3 Next held high after test 2 -> keys arrive 5 cycles apart.
//    Round=1 gives a0fafe1788542cb123a339392a6c7605; Round=0 gives 2b7e151628aed2a6abf7158809cf4f3c with Ry=1.
//    One more Next -> Valid=0, Ry=0.
//  4 Load of a new key during the 2nd SUB cycle -> step aborted; next cycle Valid=1, Round=10, Key=new KeyIn.
//    Load & Next in the same cycle -> Load wins.
//  5 Rst pulsed mid-SUB -> outputs clear asynchronously; after release, Next is ignored until a Load.
//  6 AES_FWD_PRELOAD_EN: Load KeyIn=2b7e151628aed2a6abf7158809cf4f3c -> Busy=1 for 40 cycles,
//    then Valid=1, Round=10, Key=d014f9a8c9ee2589e13f0cc8b6630ca6.

Source files
------------

// File: rtl/aes_pkg.sv
// AES shared constants: S-box and Rcon tables, key-schedule state encoding, and byte/word types.
// No ports. Imported by the forward and inverse key schedules.
package aes_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_SUB  = 2'd2;
  localparam logic [1:0] ST_PRE  = 2'd3;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Out-of-range indices only occur on idle paths; return 0 there.
  function automatic byte_t rcon_at(input logic [3:0] i);
    rcon_at = 8'h00;
    if (i < 4'd10) rcon_at = RCON[i];
  endfunction

  function automatic word_t rot_word(input word_t w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
// Ports: a (8-bit input byte), y (8-bit substituted byte).
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = SBOX[a];

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 decrypt-side round-key source: walks the key expansion backwards one key per step.
// Ports: Clk, Rst (async high), Load/KeyIn start a sequence, Next advances,
// Key/Round/Valid/Ry present the current key, Busy flags a step or preload.
// Optional macro AES_FWD_PRELOAD_EN: KeyIn is the cipher key, expanded forward first.
module aes_inv_key_schedule
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Load,
  input  logic [127:0] KeyIn,
  input  logic         Next,
  output logic [127:0] Key,
  output logic [3:0]   Round,
  output logic         Valid,
  output logic         Ry,
  output logic         Busy
);

  if (NR != 10) begin : g_bad_nr
    $error("aes_inv_key_schedule supports NR=10 only");
  end

  logic [1:0]  st;
  logic [1:0]  cnt;
  logic [23:0] sw;

  word_t w0, w1, w2, w3, p3;
  word_t sel_w, rw, subw;
  byte_t sb_in, sb_out;
  logic [127:0] inv_key;

  assign w0 = Key[127:96];
  assign w1 = Key[95:64];
  assign w2 = Key[63:32];
  assign w3 = Key[31:0];
  assign p3 = w3 ^ w2;

`ifdef AES_FWD_PRELOAD_EN
  word_t n0, n1, n2, n3;
  assign sel_w = (st == ST_PRE) ? w3 : p3;
  assign n0 = w0 ^ subw ^ {rcon_at(Round), 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
`else
  assign sel_w = p3;
`endif

  assign rw = rot_word(sel_w);
  // cnt 0 selects the MS byte: bit offset is 8*(3-cnt).
  assign sb_in = rw[{~cnt, 3'b000} +: 8];

  aes_sbox u_sbox (
    .a (sb_in),
    .y (sb_out)
  );

  // Bytes 0..2 are buffered in sw; byte 3 comes live on the last cycle.
  assign subw = {sw, sb_out};

  assign inv_key = {
    w0 ^ subw ^ {rcon_at(Round - 4'd1), 24'h0},
    w1 ^ w0,
    w2 ^ w1,
    p3
  };

  assign Ry = Valid & (Round == 4'd0);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Key   <= '0;
      Round <= '0;
      Valid <= 1'b0;
      Busy  <= 1'b0;
      st    <= ST_IDLE;
      cnt   <= '0;
      sw    <= '0;
    end else if (Load) begin
      Key <= KeyIn;
      cnt <= '0;
      sw  <= '0;
`ifdef AES_FWD_PRELOAD_EN
      Round <= 4'd0;
      Valid <= 1'b0;
      Busy  <= 1'b1;
      st    <= ST_PRE;
`else
      Round <= 4'(NR);
      Valid <= 1'b1;
      Busy  <= 1'b0;
      st    <= ST_HOLD;
`endif
    end else begin
      case (st)
        ST_IDLE: ;
        ST_HOLD: begin
          if (Next) begin
            Valid <= 1'b0;
            if (Round != 4'd0) begin
              Busy <= 1'b1;
              cnt  <= '0;
              st   <= ST_SUB;
            end else begin
              st <= ST_IDLE;
            end
          end
        end
        ST_SUB: begin
          sw  <= {sw[15:0], sb_out};
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            Key   <= inv_key;
            Round <= Round - 4'd1;
            Valid <= 1'b1;
            Busy  <= 1'b0;
            st    <= ST_HOLD;
          end
        end
`ifdef AES_FWD_PRELOAD_EN
        ST_PRE: begin
          sw  <= {sw[15:0], sb_out};
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            Key   <= {n0, n1, n2, n3};
            Round <= Round + 4'd1;
            if (Round == 4'(NR - 1)) begin
              Valid <= 1'b1;
              Busy  <= 1'b0;
              st    <= ST_HOLD;
            end
          end
        end
`endif
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule
